ram_bist_ctrl: RTL and testbench

- Built-in self-test initiator that drives the single-port synchronous RAM port (we/addr/din) and checks the RAM's registered read data (dout).
- Runs a 3-element March sequence: ascending write P; ascending read P then write ~P; descending read ~P.
- Reports pass/fail, the first failing address and data, and a mismatch count.
- Sits between the RAM instance and the test/top-level control logic; while busy it owns the RAM port.

---
 rtl/ram_bist_pkg.sv | 31 +++
 rtl/ram_bist_if.sv | 32 +++
 rtl/ram_bist_addr_gen.sv | 44 ++++
 rtl/ram_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared types and constants for the RAM BIST controller.
//   bist_state_e       : controller state encoding
//   bist_depth()       : RAM depth N for a given address width
//   bist_total_cycles(): cycles from start accept to the done pulse (4N+1)
//   BIST_TOTAL_CYCLES  : that latency for the default 4-bit address

package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_RW_RD,
        ST_RW_WR,
        ST_R1,
        ST_FLUSH,
        ST_DONE
    } bist_state_e;

    function automatic int unsigned bist_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic int unsigned bist_total_cycles(input int unsigned aw);
        return 4 * bist_depth(aw) + 1;
    endfunction

    localparam int unsigned BIST_DEF_ADDR_WIDTH = 4;
    localparam int unsigned BIST_TOTAL_CYCLES   = bist_total_cycles(BIST_DEF_ADDR_WIDTH);

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if
// Single-port synchronous RAM port as seen by the BIST controller.
//   ram_we   : write enable            (master -> RAM)
//   ram_addr : address                 (master -> RAM)
//   ram_din  : write data              (master -> RAM)
//   ram_dout : registered read data    (RAM -> master), valid one cycle
//              after the read address was presented
// Modports: master = BIST controller, slave = RAM.

interface ram_bist_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
// Up/down address counter for the March sequence.
//   clk, rst_n : clock, async active-low reset (counter -> 0)
//   load_zero  : load 0 (highest priority)
//   load_max   : load N-1
//   inc / dec  : step up / down; no command holds the value
//   addr       : current address
//   tc_up      : addr == N-1 (ascending terminal count)
//   tc_dn      : addr == 0   (descending terminal count)
// The controller switches phases on the terminal counts, so the counter
// is never asked to wrap.

module ram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_zero,
    input  logic                  load_max,
    input  logic                  inc,
    input  logic                  dec,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  tc_up,
    output logic                  tc_dn
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load_zero) begin
            addr <= '0;
        end else if (load_max) begin
            addr <= '1;
        end else if (inc) begin
            addr <= addr + ADDR_WIDTH'(1);
        end else if (dec) begin
            addr <= addr - ADDR_WIDTH'(1);
        end
    end

    assign tc_up = (addr == '1);
    assign tc_dn = (addr == '0);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// March-style RAM BIST initiator: ascending write P, ascending read P /
// write ~P, descending read ~P. Owns the RAM port while busy.
//   clk, rst_n   : clock shared with the RAM, async active-low reset
//   start        : start request, sampled only in IDLE
//   pattern      : background pattern P, latched on start accept
//   ram          : RAM port (ram_bist_if.master)
//   busy         : test in progress (cycle after accept through FLUSH)
//   done         : one-cycle completion pulse
//   pass         : 1 when the finished run saw no mismatch
//   fail_addr    : address of the first mismatch
//   fail_data    : data read at the first mismatch
//   err_count    : saturating mismatch count
// Optional build macro BIST_STOP_ON_FAIL_EN: abort to DONE on the first
// mismatch instead of running the whole sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for start, results held
// W0       | ascending write of P
// RW_RD    | present read address a
// RW_WR    | compare read of a with P, write ~P to a
// R1       | descending read, compare previous read with ~P
// FLUSH    | compare the last (address 0) read
// DONE     | done pulse, pass valid

module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    ram_bist_if.master            ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH+1:0] err_count
);

    localparam int EW = ADDR_WIDTH + 2;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    bist_state_e           state;
    logic [DATA_WIDTH-1:0] pat_q;
    logic                  exp_vld;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  tc_up;
    logic                  tc_dn;
    logic                  load_zero;
    logic                  load_max;
    logic                  inc;
    logic                  dec;

    logic                  cmp_rw;
    logic                  cmp_r1;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  mismatch;

    ram_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_zero (load_zero),
        .load_max  (load_max),
        .inc       (inc),
        .dec       (dec),
        .addr      (addr),
        .tc_up     (tc_up),
        .tc_dn     (tc_dn)
    );

    always_comb begin
        load_zero = 1'b0;
        load_max  = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        case (state)
            ST_IDLE: load_zero = start;
            ST_W0: begin
                if (tc_up) load_zero = 1'b1;
                else       inc       = 1'b1;
            end
            ST_RW_WR: begin
                if (tc_up) load_max = 1'b1;
                else       inc      = 1'b1;
            end
            ST_R1: dec = !tc_dn;
            default: ;
        endcase
    end

    // RW phase checks the read issued in RW_RD; the R1/FLUSH check uses the
    // read issued one cycle earlier, so its address comes from rd_addr.
    assign cmp_rw   = (state == ST_RW_WR);
    assign cmp_r1   = exp_vld && ((state == ST_R1) || (state == ST_FLUSH));
    assign cmp_exp  = cmp_rw ? pat_q : ~pat_q;
    assign cmp_addr = cmp_rw ? addr : rd_addr;
    assign mismatch = (cmp_rw || cmp_r1) && (ram.ram_dout != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pat_q     <= '0;
            exp_vld   <= 1'b0;
            rd_addr   <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            err_count <= '0;
        end else begin
            exp_vld <= (state == ST_R1);
            rd_addr <= addr;

            if (mismatch) begin
                if (err_count == '0) begin
                    fail_addr <= cmp_addr;
                    fail_data <= ram.ram_dout;
                end
                if (err_count != '1) begin
                    err_count <= err_count + EW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat_q     <= pattern;
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        pass      <= 1'b0;
                        state     <= ST_W0;
                    end
                end
                ST_W0: begin
                    if (tc_up) state <= ST_RW_RD;
                end
                ST_RW_RD: state <= ST_RW_WR;
                ST_RW_WR: begin
                    if (STOP_ON_FAIL && mismatch) begin
                        pass  <= 1'b0;
                        state <= ST_DONE;
                    end else if (tc_up) begin
                        state <= ST_R1;
                    end else begin
                        state <= ST_RW_RD;
                    end
                end
                ST_R1: begin
                    if (STOP_ON_FAIL && mismatch) begin
                        pass  <= 1'b0;
                        state <= ST_DONE;
                    end else if (tc_dn) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    pass  <= (err_count == '0) && !mismatch;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram.ram_we   = (state == ST_W0) || (state == ST_RW_WR);
    assign ram.ram_addr = addr;
    assign ram.ram_din  = (state == ST_W0)    ? pat_q  :
                          (state == ST_RW_WR) ? ~pat_q : '0;
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
// Directed bench for ram_bist_ctrl with a behavioural sync RAM that can
// hold a stuck-at-1 bit on one address or ignore writes to one address.
// Expectations follow BIST_STOP_ON_FAIL_EN when it is defined.

module tb_ram_bist_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] pattern = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [AW+1:0] err_count;

    ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .ram       (ram),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with fault injection
    logic [DW-1:0] mem [N];
    bit            stuck_en = 1'b0;
    logic [AW-1:0] stuck_addr = '0;
    logic [DW-1:0] stuck_or = '0;
    bit            wign_en = 1'b0;
    logic [AW-1:0] wign_addr = '0;
    bit            preset_en = 1'b0;
    logic [AW-1:0] preset_addr = '0;
    logic [DW-1:0] preset_val = '0;

    always @(posedge clk) begin
        ram.ram_dout <= mem[ram.ram_addr];
        if (preset_en) begin
            mem[preset_addr] <= preset_val;
        end else if (ram.ram_we && !(wign_en && ram.ram_addr == wign_addr)) begin
            mem[ram.ram_addr] <= (stuck_en && ram.ram_addr == stuck_addr)
                                 ? (ram.ram_din | stuck_or) : ram.ram_din;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic count_mem(input logic [DW-1:0] v, output int bad);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== v) bad++;
        end
    endtask

    // Accept a start, wait for done (bounded), then watch the idle period.
    task automatic run_bist(input logic [DW-1:0] p, input bit hold,
                            output int cyc, output int busy_gaps, output int we_after);
        start   = 1'b1;
        pattern = p;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check_eq("busy_after_accept", busy, 1);
        check_eq("pass_cleared", pass, 0);
        check_eq("err_cleared", err_count, 0);
        cyc       = 0;
        busy_gaps = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
        check_eq("done_seen", done, 1);
        check_eq("busy_low_at_done", busy, 0);
        start = 1'b0;
        we_after = 0;
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
        repeat (7) begin
            if (ram.ram_we) we_after++;
            @(posedge clk); #1;
        end
        check_eq("idle_after_run", busy, 0);
    endtask

    int cyc, gaps, wea, bad;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we", ram.ram_we, 0);
        check_eq("rst_addr", ram.ram_addr, 0);
        check_eq("rst_din", ram.ram_din, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fail_addr", fail_addr, 0);
        check_eq("rst_fail_data", fail_data, 0);
        check_eq("rst_err", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fault-free run, P=0x55
        run_bist(8'h55, 1'b0, cyc, gaps, wea);
        check_eq("t1_latency", cyc, 65);
        check_eq("t1_busy_gaps", gaps, 0);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_err", err_count, 0);
        check_eq("t1_we_after", wea, 0);
        count_mem(8'hAA, bad);
        check_eq("t1_mem_all_aa", bad, 0);

        // Stuck-at-1 on mem[5] bit 0
        stuck_en = 1'b1; stuck_addr = 4'd5; stuck_or = 8'h01;
        run_bist(8'h55, 1'b0, cyc, gaps, wea);
`ifdef BIST_STOP_ON_FAIL_EN
        check_eq("t2_latency", cyc, 60);
`else
        check_eq("t2_latency", cyc, 65);
`endif
        check_eq("t2_fail_addr", fail_addr, 5);
        check_eq("t2_fail_data", fail_data, 8'hAB);
        check_eq("t2_err", err_count, 1);
        check_eq("t2_pass", pass, 0);
        stuck_en = 1'b0;

        // Writes to address 3 ignored, mem[3] preset to 0x00
        preset_en = 1'b1; preset_addr = 4'd3; preset_val = 8'h00;
        @(posedge clk); #1;
        preset_en = 1'b0;
        wign_en = 1'b1; wign_addr = 4'd3;
        run_bist(8'h55, 1'b0, cyc, gaps, wea);
`ifdef BIST_STOP_ON_FAIL_EN
        check_eq("t3_latency", cyc, 24);
        check_eq("t3_err", err_count, 1);
`else
        check_eq("t3_latency", cyc, 65);
        check_eq("t3_err", err_count, 2);
`endif
        check_eq("t3_fail_addr", fail_addr, 3);
        check_eq("t3_fail_data", fail_data, 8'h00);
        check_eq("t3_pass", pass, 0);
        check_eq("t3_we_after", wea, 0);
        check_eq("t3_pass_hold", pass, 0);
        wign_en = 1'b0;

        // start held high for the whole run, then a fresh run with P=0xFF
        run_bist(8'h55, 1'b1, cyc, gaps, wea);
        check_eq("t4_latency", cyc, 65);
        check_eq("t4_pass", pass, 1);
        run_bist(8'hFF, 1'b0, cyc, gaps, wea);
        check_eq("t4b_latency", cyc, 65);
        check_eq("t4b_pass", pass, 1);
        count_mem(8'h00, bad);
        check_eq("t4b_mem_all_00", bad, 0);

        // Reset during the RW phase
        start = 1'b1; pattern = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_eq("t5_we_before_rst", ram.ram_we, 1);
        check_eq("t5_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_we_in_rst", ram.ram_we, 0);
        check_eq("t5_busy_in_rst", busy, 0);
        check_eq("t5_done_in_rst", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_bist(8'h55, 1'b0, cyc, gaps, wea);
        check_eq("t5_latency", cyc, 65);
        check_eq("t5_pass", pass, 1);
        check_eq("t5_err", err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
